// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronises and filters the device-driven lines, deframes
// 11-bit frames and folds E0/F0 prefixes into the toggle-style ps2_key event word.
module ps2_key_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 24000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    r_clkSync;
    logic [1:0]    r_dataSync;
    logic [FW-1:0] r_filtCnt;
    logic          r_clkFilt;
    logic          r_fall;
    state_t        r_state;
    logic [7:0]    r_sr;
    logic [2:0]    r_bitCnt;
    logic          r_par;
    logic          r_ext;
    logic          r_rel;
    logic [TW-1:0] r_wdog;
    logic          w_data;
    logic          w_timeout;

    assign w_data    = r_dataSync[1];
    assign w_timeout = busy && (r_wdog == TW'(TIMEOUT));

    // Idle PS/2 lines float high, so the synchronisers come out of reset at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
        end else begin
            r_clkSync  <= {r_clkSync[0], ps2_clk_in};
            r_dataSync <= {r_dataSync[0], ps2_data_in};
        end
    end

    // The filtered clock only follows after FILTER consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filtCnt <= '0;
            r_clkFilt <= 1'b1;
            r_fall    <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clkSync[1] == r_clkFilt) begin
                r_filtCnt <= '0;
            end else if (r_filtCnt == FW'(FILTER - 1)) begin
                r_filtCnt <= '0;
                r_clkFilt <= r_clkSync[1];
                r_fall    <= r_clkFilt;
            end else begin
                r_filtCnt <= r_filtCnt + 1'b1;
            end
        end
    end

    // Timeout outranks a coincident edge; error pulses are suppressed back-to-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_sr      <= '0;
            r_bitCnt  <= '0;
            r_par     <= 1'b0;
            r_ext     <= 1'b0;
            r_rel     <= 1'b0;
            r_wdog    <= '0;
            ps2_key   <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (w_timeout) begin
                r_state   <= IDLE;
                busy      <= 1'b0;
                r_wdog    <= '0;
                r_ext     <= 1'b0;
                r_rel     <= 1'b0;
                frame_err <= !frame_err;
            end else begin
                if (busy)
                    r_wdog <= r_fall ? '0 : r_wdog + 1'b1;
                if (r_fall) begin
                    case (r_state)
                        IDLE: begin
                            if (!w_data) begin
                                r_state  <= DATA;
                                r_bitCnt <= '0;
                                busy     <= 1'b1;
                                r_wdog   <= '0;
                            end else begin
                                frame_err <= !frame_err;
                            end
                        end
                        DATA: begin
                            r_sr     <= {w_data, r_sr[7:1]};
                            r_bitCnt <= r_bitCnt + 1'b1;
                            if (r_bitCnt == 3'd7)
                                r_state <= PARITY;
                        end
                        PARITY: begin
                            r_par   <= w_data;
                            r_state <= STOP;
                        end
                        STOP: begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                            r_wdog  <= '0;
                            if (w_data && (^{r_sr, r_par})) begin
                                if (r_sr == 8'hE0) begin
                                    r_ext <= 1'b1;
                                end else if (r_sr == 8'hF0) begin
                                    r_rel <= 1'b1;
                                end else begin
                                    ps2_key <= {~ps2_key[10], ~r_rel, r_ext, r_sr};
                                    r_ext   <= 1'b0;
                                    r_rel   <= 1'b0;
                                end
                            end else begin
                                frame_err <= !frame_err;
                                r_ext     <= 1'b0;
                                r_rel     <= 1'b0;
                            end
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Drives PS/2 frames (directed plus random) into ps2_key_rx and checks it every cycle
// against a byte-level model of the prefix/toggle rules.
module tb_ps2_key_rx;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 24000;
    localparam int HALF    = 25;

    logic        clock;
    logic        reset;
    logic        ps2Clk;
    logic        ps2Data;
    logic [10:0] ps2Key;
    logic        frameErr;
    logic        busy;

    logic [10:0] keyExp;
    logic [10:0] keyPrev;
    bit          modelExt;
    bit          modelRel;
    int          errExp;
    int          errSeen;
    bit          busyKnown;
    bit          busyExp;
    bit          prevErr;
    logic [7:0]  pendingByte;
    bit          pendingGood;
    int          total;
    int          bad;

    ps2_key_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clock),
        .reset      (reset),
        .ps2_clk_in (ps2Clk),
        .ps2_data_in(ps2Data),
        .ps2_key    (ps2Key),
        .frame_err  (frameErr),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Byte-level view of the decoder: prefixes set flags, other bytes emit a toggled event.
    task automatic modelUpdate();
        keyPrev = keyExp;
        if (pendingGood) begin
            if (pendingByte == 8'hE0) modelExt = 1'b1;
            else if (pendingByte == 8'hF0) modelRel = 1'b1;
            else begin
                keyExp   = {~keyExp[10], ~modelRel, modelExt, pendingByte};
                modelExt = 1'b0;
                modelRel = 1'b0;
            end
        end else begin
            errExp++;
            modelExt = 1'b0;
            modelRel = 1'b0;
        end
    endtask

    task automatic clockBit(input bit value, input bit glitch, input bit isLast);
        ps2Data = value;
        if (glitch) begin
            waitCycles(14);
            ps2Clk = 1'b0;
            waitCycles(3);
            ps2Clk = 1'b1;
            waitCycles(HALF - 17);
        end else begin
            waitCycles(HALF);
        end
        if (isLast) begin
            busyKnown = 1'b0;
            modelUpdate();
        end
        ps2Clk = 1'b0;
        waitCycles(HALF);
        ps2Clk = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] value, input bit badParity, input bit badStop, input bit glitch);
        bit par;
        par         = (~^value) ^ badParity;
        pendingByte = value;
        pendingGood = !badParity && !badStop;
        busyKnown   = 1'b0;
        clockBit(1'b0, 1'b0, 1'b0);
        busyExp   = 1'b1;
        busyKnown = 1'b1;
        for (int i = 0; i < 8; i++)
            clockBit(value[i], glitch && (i == 2 || i == 5), 1'b0);
        clockBit(par, glitch, 1'b0);
        clockBit(!badStop, 1'b0, 1'b1);
        ps2Data = 1'b1;
        waitCycles(20);
        busyExp   = 1'b0;
        busyKnown = 1'b1;
    endtask

    task automatic checkFrame(input string name);
        checkOutput({name, "_key"}, 32'(ps2Key), 32'(keyExp));
        checkOutput({name, "_errs"}, errSeen, errExp);
    endtask

    // Between model updates the key may still hold the previous event, nothing else.
    always @(negedge clock) begin
        if (reset) begin
            prevErr = 1'b0;
        end else begin
            total++;
            if (!(ps2Key === keyExp || ps2Key === keyPrev)) begin
                bad++;
                $display("[TB] FAIL key_track: got %h expected %h or %h", ps2Key, keyExp, keyPrev);
            end
            total++;
            if (frameErr && prevErr) begin
                bad++;
                $display("[TB] FAIL err_single: got two consecutive frame_err cycles, expected one");
            end
            if (busyKnown)
                checkOutput("busy_track", 32'(busy), 32'(busyExp));
            if (frameErr === 1'b1) errSeen++;
            prevErr = frameErr;
        end
    end

    initial begin
        total = 0; bad = 0; errExp = 0; errSeen = 0;
        keyExp = '0; keyPrev = '0; modelExt = 0; modelRel = 0;
        busyKnown = 0; busyExp = 0; prevErr = 0;
        reset = 1'b1; ps2Clk = 1'b1; ps2Data = 1'b1;
        waitCycles(5);
        checkOutput("rst_key", 32'(ps2Key), 32'h0);
        checkOutput("rst_err", 32'(frameErr), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        waitCycles(10);
        busyExp = 1'b0; busyKnown = 1'b1;

        applyStimulus(8'h1C, 0, 0, 0);
        checkFrame("plain_1C");
        checkOutput("lit_61C", 32'(ps2Key), 32'h61C);

        applyStimulus(8'hF0, 0, 0, 0);
        checkFrame("after_F0");
        applyStimulus(8'h1C, 0, 0, 0);
        checkFrame("rel_1C");
        checkOutput("lit_01C", 32'(ps2Key), 32'h01C);

        applyStimulus(8'hE0, 0, 0, 0);
        applyStimulus(8'h75, 0, 0, 0);
        checkFrame("ext_75");
        checkOutput("lit_775", 32'(ps2Key), 32'h775);

        applyStimulus(8'hE0, 0, 0, 0);
        applyStimulus(8'hF0, 0, 0, 0);
        applyStimulus(8'h75, 0, 0, 0);
        checkFrame("extrel_75");
        checkOutput("lit_175", 32'(ps2Key), 32'h175);

        applyStimulus(8'h1C, 1, 0, 0);
        checkFrame("bad_parity");
        checkOutput("lit_keep_175", 32'(ps2Key), 32'h175);
        applyStimulus(8'h1C, 0, 0, 0);
        checkFrame("recover_1C");
        checkOutput("lit_toggle_61C", 32'(ps2Key), 32'h61C);

        // Prefix then a frame abandoned after five bits; the watchdog must end it.
        applyStimulus(8'hE0, 0, 0, 0);
        busyKnown = 1'b0;
        clockBit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            clockBit(1'b1, 1'b0, 1'b0);
        errExp++;
        modelExt = 1'b0;
        modelRel = 1'b0;
        waitCycles(TIMEOUT + 40);
        checkOutput("timeout_busy", 32'(busy), 32'h0);
        checkOutput("timeout_errs", errSeen, errExp);
        busyExp = 1'b0; busyKnown = 1'b1;
        applyStimulus(8'h75, 0, 0, 0);
        checkFrame("post_timeout_75");
        checkOutput("lit_275", 32'(ps2Key), 32'h275);

        // Lone clock pulse with data high is a bad start bit.
        errExp++;
        clockBit(1'b1, 1'b0, 1'b0);
        waitCycles(20);
        checkOutput("bad_start_errs", errSeen, errExp);

        applyStimulus(8'h5A, 0, 0, 1);
        checkFrame("glitch_5A");
        applyStimulus(8'h2B, 0, 1, 0);
        checkFrame("bad_stop");

        busyKnown = 1'b0;
        clockBit(1'b0, 1'b0, 1'b0);
        clockBit(1'b1, 1'b0, 1'b0);
        clockBit(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        ps2Clk = 1'b1; ps2Data = 1'b1;
        keyExp = '0; keyPrev = '0; modelExt = 0; modelRel = 0;
        waitCycles(3);
        checkOutput("midrst_key", 32'(ps2Key), 32'h0);
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        waitCycles(30);
        busyExp = 1'b0; busyKnown = 1'b1;
        applyStimulus(8'h1C, 0, 0, 0);
        checkFrame("post_rst_1C");
        checkOutput("lit_post_rst_61C", 32'(ps2Key), 32'h61C);

        for (int n = 0; n < 25; n++) begin
            int sel;
            logic [7:0] value;
            bit badPar;
            bit badStp;
            sel    = int'($urandom_range(0, 9));
            value  = (sel < 2) ? 8'hE0 : (sel < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
            badPar = ($urandom_range(0, 7) == 0);
            badStp = !badPar && ($urandom_range(0, 9) == 0);
            applyStimulus(value, badPar, badStp, $urandom_range(0, 3) == 0);
            checkFrame("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_rx.md
Name: ps2_key_rx

Overview:
- Receives the raw PS/2 keyboard serial stream (device-driven clock and data lines) and decodes it into the 11-bit `ps2_key` event word that the Keyboard voice-allocation block consumes.
- Lets the synth be driven from a physical PS/2 keyboard on the user port instead of the HPS-forwarded `ps2_key`.
- Handles line synchronisation, glitch filtering, frame reception, parity check and E0/F0 prefix decoding.

Parameters:
- FILTER, 8: consecutive identical `clk` samples required before the filtered `ps2_clk` changes state.
- TIMEOUT, 24000: `clk` cycles without a filtered falling edge mid-frame before the frame is aborted (1 ms at 24 MHz).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-high
- ps2_clk_in  input  1  raw PS/2 clock line, asynchronous to `clk`
- ps2_data_in  input  1  raw PS/2 data line, asynchronous to `clk`
- ps2_key  output  11  [10] toggle, [9] pressed, [8] extended, [7:0] scancode
- frame_err  output  1  one-cycle pulse on parity, start, stop or timeout error
- busy  output  1  high while a frame is in progress

Behaviour:
- **Reset values.** Async reset clears all state. `ps2_key`=11'h000, `frame_err`=0, `busy`=0, ext/rel prefix flags=0, FSM=IDLE.
- **Input conditioning.** Both lines pass through 2-FF synchronisers. `ps2_clk` then goes through a counter filter: the filtered level changes only after FILTER consecutive equal samples. A falling-edge strobe `fall` is asserted for one cycle when the filtered clock goes 1->0. Data is taken from the synchronised `ps2_data` on the `fall` cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0, go to DATA, bitcnt=0, `busy`=1. On `fall` with data=1 (bad start), pulse `frame_err` and stay in IDLE.
  - DATA: on each `fall`, shift data into `sr[7:0]` LSB-first, bitcnt++. After 8 bits, go to PARITY.
  - PARITY: on `fall`, latch parity bit and go to STOP.
  - STOP: on `fall`, check stop=1 and odd parity (^{sr, par}==1). Then return to IDLE and clear `busy`.
- **Timeout.** A watchdog counter resets on every `fall` while `busy`=1. When it reaches TIMEOUT, the FSM returns to IDLE, `busy`=0, `frame_err` pulses, and the prefix flags clear.
- **Byte handling.** Applies on a good frame, registered one cycle after the stop-bit `fall`:
  - 8'hE0: set ext. No output.
  - 8'hF0: set rel. No output.
  - Any other byte: `ps2_key` <= {~ps2_key[10], ~rel, ext, byte}, then clear ext and rel.
- **Bad frame.** Parity or stop error: pulse `frame_err`, leave `ps2_key` unchanged, clear the prefix flags.
- **Errors are single-cycle.** `frame_err` never asserts on two consecutive cycles. `ps2_key` changes only via the toggle-update rule, so consumers detect new events by a change on bit 10.
- **Simultaneous events.** A `fall` on the same cycle as the timeout terminal count: the timeout wins and that edge is discarded.
- **Unsupported sequences.** E1 and the Pause sequence are not special-cased; they are emitted as ordinary codes.
- **Reset mid-frame.** Partial frame and prefix flags are discarded. Reception restarts from IDLE after reset deasserts.

Test Plan:
- After reset, send frame 8'h1C (data LSB-first, parity=0, stop=1) -> `ps2_key`=11'h61C one cycle after the stop-bit `fall`; `frame_err` stays 0; `busy` 1 during the frame, 0 after.
- Then send F0 (parity 1) followed by 1C (parity 0) -> no output after F0; after 1C `ps2_key`=11'h01C.
- Send E0 (parity 0) then 75 (parity 0) -> 11'h775. Then send E0, F0, 75 -> 11'h175.
- Send 1C with parity=1 -> one-cycle `frame_err`, `ps2_key` unchanged. A following good 1C -> bit 10 toggles, ext=0, rel=0.
- Send E0, then start a frame and stall after 5 bits for TIMEOUT+10 cycles -> `frame_err` pulse, `busy`=0. A following good 75 -> 11'h_75 with ext=0.
- Inject 3-cycle (< FILTER) low glitches on `ps2_clk_in` during a frame -> no extra bits, correct decode. Assert reset mid-frame -> outputs return to 0, and the next clean frame decodes correctly.
